reorder_out_gearbox: RTL and testbench

// Output stage downstream of the reorder store. On command it reads one stored codeword
// (raw or corrected copy, bank A/B) from address 0 upward, one 10b symbol per cycle,

---
 rtl/reorder_out_gearbox.sv | 162 ++++++++++++++++
 tb/tb_reorder_out_gearbox.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_out_gearbox.sv
// Output gearbox: reads one stored codeword, one symbol per cycle, from the selected bank/copy
// and packs the symbols MSB-first into OUT_W-bit words on a valid/ready stream.
module reorder_out_gearbox #(
    parameter int W      = 10,
    parameter int N      = 544,
    parameter int K      = 522,
    parameter int OUT_W  = 64,
    parameter int SEND_N = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  start_sel_i,
    input  logic                  use_raw_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            raw_rd_en_o,
    output logic [1:0][9:0]       raw_rd_addr_o,
    input  logic [1:0][W-1:0]     raw_rd_dout_i,
    output logic [1:0]            rec_rd_en_o,
    output logic [1:0][9:0]       rec_rd_addr_o,
    input  logic [1:0][W-1:0]     rec_rd_dout_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OUT_W-1:0]      out_data_o,
    output logic                  out_last_o,
    output logic [6:0]            out_nbits_o
);

    localparam int L   = (SEND_N != 0) ? N : K;
    localparam int ACC = OUT_W + W;
    localparam int AW  = 10;
    localparam int FW  = $clog2(ACC + OUT_W + W + 1);

    localparam logic [FW-1:0] C_W    = FW'(W);
    localparam logic [FW-1:0] C_OUTW = FW'(OUT_W);
    localparam logic [FW-1:0] C_ACC  = FW'(ACC);
    localparam logic [AW-1:0] C_LAST = AW'(L - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sel, r_raw, r_pend;
    logic [AW-1:0]     r_addr;
    logic [ACC-1:0]    r_acc;
    logic [FW-1:0]     r_fill;
    logic              r_out_valid, r_out_last;
    logic [OUT_W-1:0]  r_out_data;
    logic [6:0]        r_out_nbits;

    logic [W-1:0]      w_sym;
    logic [ACC-1:0]    w_acc;
    logic [FW-1:0]     w_fill;
    logic              w_slot_free, w_drain_full, w_drain_tail, w_issue, w_all_landed;

    // Fill and contents already include the symbol landing this cycle, so a full word can
    // drain in the same cycle its final bits arrive and the read pipe never bubbles.
    always_comb begin
        w_sym        = r_raw ? raw_rd_dout_i[r_sel] : rec_rd_dout_i[r_sel];
        w_acc        = r_acc;
        w_fill       = r_fill;
        if (r_pend) begin
            w_acc  = r_acc | ({w_sym, {(ACC-W){1'b0}}} >> r_fill);
            w_fill = r_fill + C_W;
        end
        w_all_landed = (r_state == S_FLUSH);
        w_slot_free  = !r_out_valid || out_ready_i;
        w_drain_full = w_slot_free && (w_fill >= C_OUTW);
        w_drain_tail = w_slot_free && w_all_landed && (w_fill != '0) && (w_fill < C_OUTW);
        w_issue      = (r_state == S_READ) &&
                       ((w_fill + C_W) <= (C_ACC + (w_drain_full ? C_OUTW : '0)));
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_READ;
            S_READ: begin
                busy_o = 1'b1;
                if (w_issue && (r_addr == C_LAST)) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy_o = 1'b1;
                if (r_out_valid && r_out_last && out_ready_i) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        raw_rd_en_o   = '0;
        rec_rd_en_o   = '0;
        raw_rd_addr_o = '0;
        rec_rd_addr_o = '0;
        if (r_raw) begin
            raw_rd_en_o[r_sel]   = w_issue;
            raw_rd_addr_o[r_sel] = r_addr;
        end else begin
            rec_rd_en_o[r_sel]   = w_issue;
            rec_rd_addr_o[r_sel] = r_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_raw       <= 1'b0;
            r_pend      <= 1'b0;
            r_addr      <= '0;
            r_acc       <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_nbits <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_issue;
            if ((r_state == S_IDLE) && start_i) begin
                r_sel  <= start_sel_i;
                r_raw  <= use_raw_i;
                r_addr <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_drain_full) begin
                r_acc  <= w_acc << OUT_W;
                r_fill <= w_fill - C_OUTW;
            end else if (w_drain_tail) begin
                r_acc  <= '0;
                r_fill <= '0;
            end else begin
                r_acc  <= w_acc;
                r_fill <= w_fill;
            end

            // A full word exactly exhausting the frame carries last itself.
            if (w_drain_full || w_drain_tail) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc[ACC-1 -: OUT_W];
                r_out_last  <= w_drain_tail || (w_all_landed && (w_fill == C_OUTW));
                r_out_nbits <= w_drain_full ? 7'(OUT_W) : w_fill[6:0];
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;
    assign out_nbits_o = r_out_nbits;

endmodule

// File: tb/tb_reorder_out_gearbox.sv
// Self-checking bench for reorder_out_gearbox: bank memories, random backpressure and a
// bit-level reference model of the packed output stream.
module tb_reorder_out_gearbox;

    localparam int W = 10;
    localparam int N = 544;
    localparam int K = 522;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [6:0]  nbits;
    } word_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetN;
    logic start0, startSel0, useRaw0, ready0;
    logic start1, startSel1, useRaw1, ready1;
    logic randReady;

    logic busy0, done0, valid0, last0;
    logic [63:0] data0;
    logic [6:0] nbits0;
    logic [1:0] rawEn0, recEn0;
    logic [1:0][9:0] rawAddr0, recAddr0, rawDout0, recDout0;

    logic busy1, done1, valid1, last1;
    logic [63:0] data1;
    logic [6:0] nbits1;
    logic [1:0] rawEn1, recEn1;
    logic [1:0][9:0] rawAddr1, recAddr1, rawDout1, recDout1;

    logic [9:0] memRaw [2][N];
    logic [9:0] memRec [2][N];

    int assertCount = 0;
    int failCount = 0;
    int cycleCount = 0;

    int curBank0, curRaw0, gotWords0, doneCount0, badEn0, badAddr0, nextAddr0, maxAddr0;
    int firstRead0, lastRead0, lastAccept0, doneCycle0;
    logic [63:0] capWord0, capWord15;
    logic stall0 = 1'b0;
    word_t heldW;

    int gotWords1 = 0;
    int maxAddr1 = 0;
    int lastNbits1 = 0;

    reorder_out_gearbox #(.W(W), .N(N), .K(K), .OUT_W(64), .SEND_N(0)) dut0 (
        .clk_i(clock), .rst_ni(resetN), .start_i(start0), .start_sel_i(startSel0),
        .use_raw_i(useRaw0), .busy_o(busy0), .done_o(done0),
        .raw_rd_en_o(rawEn0), .raw_rd_addr_o(rawAddr0), .raw_rd_dout_i(rawDout0),
        .rec_rd_en_o(recEn0), .rec_rd_addr_o(recAddr0), .rec_rd_dout_i(recDout0),
        .out_valid_o(valid0), .out_ready_i(ready0), .out_data_o(data0),
        .out_last_o(last0), .out_nbits_o(nbits0)
    );

    reorder_out_gearbox #(.W(W), .N(N), .K(K), .OUT_W(64), .SEND_N(1)) dut1 (
        .clk_i(clock), .rst_ni(resetN), .start_i(start1), .start_sel_i(startSel1),
        .use_raw_i(useRaw1), .busy_o(busy1), .done_o(done1),
        .raw_rd_en_o(rawEn1), .raw_rd_addr_o(rawAddr1), .raw_rd_dout_i(rawDout1),
        .rec_rd_en_o(recEn1), .rec_rd_addr_o(recAddr1), .rec_rd_dout_i(recDout1),
        .out_valid_o(valid1), .out_ready_i(ready1), .out_data_o(data1),
        .out_last_o(last1), .out_nbits_o(nbits1)
    );

    // Synchronous-read store model: data appears the cycle after the enable.
    always @(posedge clock) begin
        cycleCount <= cycleCount + 1;
        for (int b = 0; b < 2; b++) begin
            if (rawEn0[b]) rawDout0[b] <= memRaw[b][rawAddr0[b]];
            if (recEn0[b]) recDout0[b] <= memRec[b][recAddr0[b]];
            if (rawEn1[b]) rawDout1[b] <= memRaw[b][rawAddr1[b]];
            if (recEn1[b]) recDout1[b] <= memRec[b][recAddr1[b]];
        end
    end

    always @(posedge clock) begin
        #1;
        ready0 = randReady ? ($urandom_range(0, 99) < 40) : 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected word idx: the frame is the concatenation of symbols 0..len-1, cut into 64-bit words.
    function automatic word_t expectedWord(input int sendN, input int bank, input int useRaw, input int idx);
        word_t r;
        int len, totalBits, g, s, bitPos, remaining;
        logic [9:0] v;
        len = sendN ? N : K;
        totalBits = len * W;
        r.data = '0;
        for (int b = 0; b < 64; b++) begin
            g = idx * 64 + b;
            if (g < totalBits) begin
                s = g / W;
                bitPos = W - 1 - (g % W);
                v = useRaw ? memRaw[bank][s] : memRec[bank][s];
                r.data[63-b] = v[bitPos];
            end
        end
        remaining = totalBits - idx * 64;
        r.nbits = (remaining >= 64) ? 7'd64 : 7'(remaining);
        r.last = (idx == (totalBits + 63) / 64 - 1);
        return r;
    endfunction

    always @(negedge clock) begin
        word_t expW;
        logic selEn;
        logic [9:0] selAddr;
        if (!resetN) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                checkOutput("hold valid", 64'(valid0), 64'd1);
                checkOutput("hold data", data0, heldW.data);
                checkOutput("hold last/nbits", 64'({last0, nbits0}), 64'({heldW.last, heldW.nbits}));
            end
            if (valid0 && ready0) begin
                expW = expectedWord(0, curBank0, curRaw0, gotWords0);
                checkOutput("word data", data0, expW.data);
                checkOutput("word last/nbits", 64'({last0, nbits0}), 64'({expW.last, expW.nbits}));
                if (gotWords0 == 0) capWord0 = data0;
                if (gotWords0 == 15) capWord15 = data0;
                if (last0) lastAccept0 = cycleCount;
                gotWords0++;
            end
            stall0 = valid0 && !ready0;
            heldW = {data0, last0, nbits0};
            if (done0) begin
                doneCount0++;
                doneCycle0 = cycleCount;
            end
            for (int b = 0; b < 2; b++) begin
                if (rawEn0[b] && !(curRaw0 == 1 && b == curBank0)) badEn0++;
                if (recEn0[b] && !(curRaw0 == 0 && b == curBank0)) badEn0++;
            end
            selEn = curRaw0 ? rawEn0[curBank0] : recEn0[curBank0];
            selAddr = curRaw0 ? rawAddr0[curBank0] : recAddr0[curBank0];
            if (selEn) begin
                if (int'(selAddr) != nextAddr0) badAddr0++;
                if (nextAddr0 == 0) firstRead0 = cycleCount;
                lastRead0 = cycleCount;
                maxAddr0 = int'(selAddr);
                nextAddr0++;
            end
        end
    end

    always @(negedge clock) begin
        word_t expW;
        if (resetN) begin
            if (valid1 && ready1) begin
                expW = expectedWord(1, 0, 0, gotWords1);
                checkOutput("sendN word data", data1, expW.data);
                checkOutput("sendN last/nbits", 64'({last1, nbits1}), 64'({expW.last, expW.nbits}));
                if (last1) lastNbits1 = int'(nbits1);
                gotWords1++;
            end
            if (recEn1[0] && int'(recAddr1[0]) > maxAddr1) maxAddr1 = int'(recAddr1[0]);
        end
    end

    task automatic applyStimulus(input int bank, input int useRaw);
        curBank0 = bank;
        curRaw0 = useRaw;
        gotWords0 = 0;
        doneCount0 = 0;
        badEn0 = 0;
        badAddr0 = 0;
        nextAddr0 = 0;
        maxAddr0 = -1;
        firstRead0 = 0;
        lastRead0 = 0;
        lastAccept0 = -10;
        doneCycle0 = 0;
        startSel0 = bank[0];
        useRaw0 = useRaw[0];
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        checkOutput("busy after start", 64'(busy0), 64'd1);
    endtask

    task automatic waitDone0(input string tag, input int budget);
        int n;
        n = 0;
        while (!done0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!done0) checkOutput({tag, " done timeout"}, 64'd0, 64'd1);
    endtask

    task automatic waitWords0(input int count, input int budget);
        int n;
        n = 0;
        while (gotWords0 < count && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (gotWords0 < count) checkOutput("word wait timeout", 64'(gotWords0), 64'(count));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " ctrl"}, 64'({busy0, done0, valid0, last0, nbits0, rawEn0, recEn0}), 64'd0);
        checkOutput({tag, " data"}, data0, 64'd0);
        checkOutput({tag, " addr"}, 64'({rawAddr0, recAddr0}), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int n;
        resetN = 1'b0;
        randReady = 1'b0;
        start0 = 1'b0; startSel0 = 1'b0; useRaw0 = 1'b0;
        start1 = 1'b0; startSel1 = 1'b0; useRaw1 = 1'b0; ready1 = 1'b1;
        for (int a = 0; a < N; a++) begin
            memRec[0][a] = 10'(a);
            memRaw[0][a] = 10'(a);
            memRec[1][a] = 10'($urandom);
            memRaw[1][a] = 10'($urandom);
        end
        @(posedge clock);
        #1;
        checkIdleOutputs("reset");
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] ramp, bank A corrected copy, ready high");
        applyStimulus(0, 0);
        waitDone0("ramp", 3000);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("ramp word count", 64'(gotWords0), 64'd82);
        // Symbols 0..5 fill bits 63..4, top nibble of symbol 6 is zero.
        checkOutput("ramp word0", capWord0, 64'h0000_1008_0301_0050);
        checkOutput("ramp done count", 64'(doneCount0), 64'd1);
        checkOutput("ramp done latency", 64'(doneCycle0 - lastAccept0), 64'd1);
        checkOutput("ramp stray enables", 64'(badEn0), 64'd0);
        checkOutput("ramp addr order", 64'(badAddr0), 64'd0);
        checkOutput("ramp final addr", 64'(maxAddr0), 64'd521);
        checkOutput("ramp read span", 64'(lastRead0 - firstRead0), 64'd521);

        $display("[TB] ramp with random backpressure");
        randReady = 1'b1;
        applyStimulus(0, 0);
        waitDone0("backpressure", 8000);
        randReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("bp word count", 64'(gotWords0), 64'd82);
        checkOutput("bp done count", 64'(doneCount0), 64'd1);
        checkOutput("bp addr order", 64'(badAddr0), 64'd0);

        $display("[TB] raw and corrected copies differ at address 100");
        memRaw[0][100] = 10'h155;
        memRec[0][100] = 10'h2AA;
        applyStimulus(0, 0);
        waitDone0("rec copy", 3000);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rec field 100", 64'(capWord15[23:14]), 64'h2AA);
        checkOutput("rec stray enables", 64'(badEn0), 64'd0);
        applyStimulus(0, 1);
        waitDone0("raw copy", 3000);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("raw field 100", 64'(capWord15[23:14]), 64'h155);
        checkOutput("raw stray enables", 64'(badEn0), 64'd0);
        checkOutput("raw word count", 64'(gotWords0), 64'd82);

        $display("[TB] bank B with stray starts mid-frame and in DONE");
        applyStimulus(1, 0);
        waitWords0(30, 2000);
        startSel0 = 1'b0;
        useRaw0 = 1'b1;
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        waitDone0("bank B", 3000);
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        checkOutput("bank B busy after done", 64'(busy0), 64'd0);
        checkOutput("bank B done count", 64'(doneCount0), 64'd1);
        checkOutput("bank B word count", 64'(gotWords0), 64'd82);
        checkOutput("bank B stray enables", 64'(badEn0), 64'd0);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(0, 0);
        waitWords0(40, 2000);
        resetN = 1'b0;
        @(posedge clock);
        #1;
        checkIdleOutputs("mid reset");
        resetN = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(0, 1);
        waitDone0("post reset", 3000);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("post reset word count", 64'(gotWords0), 64'd82);
        checkOutput("post reset done count", 64'(doneCount0), 64'd1);
        checkOutput("post reset addr order", 64'(badAddr0), 64'd0);

        $display("[TB] full codeword including parity");
        memRec[0][100] = 10'd100;
        start1 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 3000) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("sendN done seen", 64'(done1), 64'd1);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("sendN word count", 64'(gotWords1), 64'd85);
        checkOutput("sendN last nbits", 64'(lastNbits1), 64'd64);
        checkOutput("sendN max addr", 64'(maxAddr1), 64'd543);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
